// File: rtl/bc_msg_sequencer.sv
// Bus-controller message sequencer in front of one Core_1553B instance.
// Runs a complete BC->RT or RT->BC message from a single command word.
// Data words are buffered locally so a message that draws no response
// can be replayed on the alternate bus.
module bc_msg_sequencer #(
   parameter int RESP_TIMEOUT = 1600,
   parameter int MAX_RETRY    = 1,
   parameter int TCNT_W       = 12
) (
   input  logic        APB_CLK,
   input  logic        APB_RESET,
   input  logic        start,
   input  logic [15:0] cmd_word,
   output logic        busy,
   output logic        done,
   output logic [1:0]  err_code,
   output logic [15:0] status_word,
   input  logic        src_valid,
   output logic        src_ready,
   input  logic [15:0] src_data,
   output logic        snk_valid,
   input  logic        snk_ready,
   output logic [15:0] snk_data,
   output logic        tx_wd,
   input  logic        tx_unfull,
   output logic [23:0] tx_data,
   output logic        rx_rd,
   input  logic        rx_unempty,
   input  logic [23:0] rx_data,
   output logic        bus_sel
);

   typedef enum logic [3:0] {
      S_IDLE, S_LOAD, S_TX_CMD, S_TX_DATA, S_WAIT_STAT,
      S_RX_DATA, S_FLUSH, S_DRAIN, S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [15:0]         cmd_q, cmd_d;
   logic [4:0]          idx_q, idx_d;
   logic [7:0]          retry_q, retry_d;
   logic                bus_sel_q, bus_sel_d;
   logic [1:0]          err_q, err_d;
   logic [15:0]         status_q, status_d;
   logic [TCNT_W-1:0]   tcnt_q, tcnt_d;

   logic [15:0]         buf_mem [32];
   logic                buf_we;
   logic [15:0]         buf_wdata;
   logic [15:0]         rd_word;
   logic                last_word;
   logic                timed_out;

   // idx 0..N-1 with N = 0 meaning 32: the 5-bit wrap of N-1 gives 31 for that case
   assign last_word = (idx_q == 5'(cmd_q[4:0] - 5'd1));
   assign timed_out = (tcnt_q == TCNT_W'(RESP_TIMEOUT));
   assign rd_word   = buf_mem[idx_q];

   assign busy        = (state_q != S_IDLE);
   assign done        = (state_q == S_DONE);
   assign err_code    = err_q;
   assign status_word = status_q;
   assign bus_sel     = bus_sel_q;

   // Message buffer write port; contents are not reset (RAM)
   always_ff @(posedge APB_CLK) begin
      if (buf_we) buf_mem[idx_q] <= buf_wdata;
   end

   // State and datapath registers
   always_ff @(posedge APB_CLK) begin
      if (APB_RESET) begin
         state_q   <= S_IDLE;
         cmd_q     <= '0;
         idx_q     <= '0;
         retry_q   <= '0;
         bus_sel_q <= 1'b0;
         err_q     <= 2'd0;
         status_q  <= '0;
         tcnt_q    <= '0;
      end else begin
         state_q   <= state_d;
         cmd_q     <= cmd_d;
         idx_q     <= idx_d;
         retry_q   <= retry_d;
         bus_sel_q <= bus_sel_d;
         err_q     <= err_d;
         status_q  <= status_d;
         tcnt_q    <= tcnt_d;
      end
   end

   // Next-state logic and handshake strobes
   always_comb begin
      state_d   = state_q;
      cmd_d     = cmd_q;
      idx_d     = idx_q;
      retry_d   = retry_q;
      bus_sel_d = bus_sel_q;
      err_d     = err_q;
      status_d  = status_q;
      tcnt_d    = tcnt_q;
      buf_we    = 1'b0;
      buf_wdata = src_data;
      src_ready = 1'b0;
      snk_valid = 1'b0;
      snk_data  = '0;
      tx_wd     = 1'b0;
      tx_data   = '0;
      rx_rd     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               cmd_d     = cmd_word;
               retry_d   = '0;
               bus_sel_d = 1'b0;
               err_d     = 2'd0;
               idx_d     = '0;
               state_d   = cmd_word[10] ? S_TX_CMD : S_LOAD;
            end
         end
         S_LOAD: begin
            src_ready = 1'b1;
            if (src_valid) begin
               buf_we    = 1'b1;
               buf_wdata = src_data;
               if (last_word) begin
                  idx_d   = '0;
                  state_d = S_TX_CMD;
               end else begin
                  idx_d = idx_q + 5'd1;
               end
            end
         end
         S_TX_CMD: begin
            if (tx_unfull) begin
               tx_wd   = 1'b1;
               tx_data = {7'd0, 1'b1, cmd_q};
               idx_d   = '0;
               tcnt_d  = '0;
               state_d = cmd_q[10] ? S_WAIT_STAT : S_TX_DATA;
            end
         end
         S_TX_DATA: begin
            if (tx_unfull) begin
               tx_wd   = 1'b1;
               tx_data = {7'd0, 1'b0, rd_word};
               if (last_word) begin
                  idx_d   = '0;
                  tcnt_d  = '0;
                  state_d = S_WAIT_STAT;
               end else begin
                  idx_d = idx_q + 5'd1;
               end
            end
         end
         S_WAIT_STAT, S_RX_DATA: begin
            // An arriving word takes priority over an expiring counter
            if (rx_unempty) begin
               rx_rd  = 1'b1;
               tcnt_d = '0;
               if (state_q == S_WAIT_STAT) begin
                  status_d = rx_data[15:0];
                  idx_d    = '0;
                  if (!rx_data[16] || rx_data[15:11] != cmd_q[15:11]) begin
                     err_d   = 2'd2;
                     state_d = S_DONE;
                  end else if (rx_data[10]) begin
                     err_d   = 2'd3;
                     state_d = S_DONE;
                  end else begin
                     state_d = cmd_q[10] ? S_RX_DATA : S_DONE;
                  end
               end else if (rx_data[16]) begin
                  err_d   = 2'd2;
                  state_d = S_DONE;
               end else begin
                  buf_we    = 1'b1;
                  buf_wdata = rx_data[15:0];
                  if (last_word) begin
                     idx_d   = '0;
                     state_d = S_DRAIN;
                  end else begin
                     idx_d = idx_q + 5'd1;
                  end
               end
            end else if (timed_out) begin
               if (int'(retry_q) < MAX_RETRY) begin
                  retry_d   = retry_q + 8'd1;
                  bus_sel_d = ~bus_sel_q;
                  state_d   = S_FLUSH;
               end else begin
                  err_d   = 2'd1;
                  state_d = S_DONE;
               end
            end else begin
               tcnt_d = tcnt_q + TCNT_W'(1);
            end
         end
         S_FLUSH: begin
            // Discard any late words from the failed attempt before resending
            if (rx_unempty) begin
               rx_rd = 1'b1;
            end else begin
               idx_d   = '0;
               state_d = S_TX_CMD;
            end
         end
         S_DRAIN: begin
            snk_valid = 1'b1;
            snk_data  = rd_word;
            if (snk_ready) begin
               if (last_word) begin
                  idx_d   = '0;
                  state_d = S_DONE;
               end else begin
                  idx_d = idx_q + 5'd1;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule
